// File: rtl/data_memory_lsu.sv
// Byte-addressable data RAM with RISC-V sub-word load/store.
// Valid/ready request channel, pipelined in-order response channel.
module data_memory_lsu #(
    parameter int DEPTH_LOG2 = 15,
    parameter int OUT_REG    = 0,
    parameter int WORD_LEN   = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [31:0]         req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    input  logic [2:0]          req_funct3,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic [1:0]          resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic                  r_ready;
    logic                  w_accept;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_illegal;
    logic                  w_misal;
    logic                  w_oor;
    logic [1:0]            w_err;
    logic [3:0]            w_be;
    logic [WORD_LEN-1:0]   w_wdata;
    logic                  w_we;

    logic [WORD_LEN-1:0]   r_mem [0:DEPTH-1];
    logic [WORD_LEN-1:0]   r_rdata;

    logic                  r_s1_valid;
    logic                  r_s1_wen;
    logic [1:0]            r_s1_lane;
    logic [2:0]            r_s1_f3;
    logic [1:0]            r_s1_err;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [WORD_LEN-1:0]   w_ext;
    logic [WORD_LEN-1:0]   w_s1_data;
    logic [1:0]            w_s1_err;

    assign req_ready = r_ready;
    assign w_accept  = req_valid & r_ready;
    assign w_idx     = req_addr[DEPTH_LOG2+1:2];
    assign w_oor     = (req_addr >> (DEPTH_LOG2 + 2)) != 32'd0;

    // Ready rises on the first edge after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_ready <= 1'b0;
        else          r_ready <= 1'b1;
    end

    // Request error classification, illegal > misaligned > range
    always_comb begin
        w_illegal = 1'b0;
        w_misal   = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = req_wen;
            default:                w_illegal = 1'b1;
        endcase
        case (req_funct3[1:0])
            2'b01:   w_misal = req_addr[0];
            2'b10:   w_misal = req_addr[1:0] != 2'b00;
            default: w_misal = 1'b0;
        endcase
        if (w_illegal)    w_err = 2'b11;
        else if (w_misal) w_err = 2'b01;
        else if (w_oor)   w_err = 2'b10;
        else              w_err = 2'b00;
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    assign w_we = w_accept & req_wen & (w_err == 2'b00);

    // Byte-write block RAM; read only on accepted loads
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
        if (w_accept && !req_wen) r_rdata <= r_mem[w_idx];
    end

    // Metadata travelling alongside the RAM read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_wen   <= 1'b0;
            r_s1_lane  <= 2'b00;
            r_s1_f3    <= 3'b000;
            r_s1_err   <= 2'b00;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_wen   <= req_wen;
            r_s1_lane  <= req_addr[1:0];
            r_s1_f3    <= req_funct3;
            r_s1_err   <= w_err;
        end
    end

    assign w_byte = r_rdata[8*r_s1_lane +: 8];
    assign w_half = r_s1_lane[1] ? r_rdata[31:16] : r_rdata[15:0];

    // Lane select and sign/zero extension of load data
    always_comb begin
        case (r_s1_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = r_rdata;
        endcase
    end

    assign w_s1_data = (r_s1_valid && !r_s1_wen && r_s1_err == 2'b00)
                       ? w_ext : '0;
    assign w_s1_err  = r_s1_valid ? r_s1_err : 2'b00;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                r_s2_valid;
            logic [WORD_LEN-1:0] r_s2_data;
            logic [1:0]          r_s2_err;

            // Optional output register stage
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                    r_s2_err   <= 2'b00;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    r_s2_data  <= w_s1_data;
                    r_s2_err   <= w_s1_err;
                end
            end

            assign resp_valid = r_s2_valid;
            assign resp_rdata = r_s2_data;
            assign resp_err   = r_s2_err;
        end else begin : g_no_out_reg
            assign resp_valid = r_s1_valid;
            assign resp_rdata = w_s1_data;
            assign resp_err   = w_s1_err;
        end
    endgenerate

endmodule
